data_mem_responder: RTL
=======================

// Module: data_mem_responder
// PURPOSE
//   Data-memory responder for the CPU load/store path: the memory-side end of the
//   MemRead/MemWrite interface. Accepts one word request at a time over a valid/ready
//   handshake, models a fixed number of wait states, and returns read data or a write
//   acknowledge over a second valid/ready channel. Holds its own word-addressed storage.
// PARAMETERS
//   ADDR_W       32   byte-address width of req_addr
//   DEPTH_WORDS  256  number of 32-bit words of storage (power of two, >=4)
//   WAIT_CYCLES  2    wait states between accept and access (0..15)
// PORTS
//   clk         in   1       clock, all logic on rising edge
//   rst         in   1       synchronous reset, active-high
//   req_valid   in   1       request present
//   req_ready   out  1       responder can accept a request
//   req_write   in   1       1 = store (MemWrite), 0 = load (MemRead)
//   req_addr    in   ADDR_W  byte address
//   req_wdata   in   32      store data
//   req_be      in   4       store byte enables, bit i -> wdata[8i+7:8i]
//   resp_valid  out  1       response present
//   resp_ready  in   1       requester consumes response
//   resp_rdata  out  32      load data (0 for stores and errors)
//   resp_err    out  1       misaligned or out-of-range request
//   busy        out  1       1 whenever state != IDLE
// BEHAVIOUR
//   - Reset (rst=1 at edge): state IDLE, counter 0, resp_valid=0, resp_rdata=0,
//     resp_err=0, busy=0; req_ready=1 from the first cycle with rst=0. Storage
//     contents are NOT touched by rst.
//   - FSM: IDLE -> WAIT -> RESP -> IDLE.
//     IDLE: req_ready=1. On req_valid&&req_ready latch write/addr/wdata/be,
//       load counter=WAIT_CYCLES, go WAIT.
//     WAIT: req_ready=0. If counter!=0 decrement. If counter==0 perform access at
//       this edge, register resp_rdata/resp_err, go RESP.
//     RESP: resp_valid=1, rdata/err stable. On resp_ready go IDLE; no new request
//       is accepted in the same cycle (req_ready only in IDLE).
//   - Latency: accept edge to first resp_valid=1 cycle = WAIT_CYCLES+2 cycles;
//     sustained throughput one request per WAIT_CYCLES+3 cycles with resp_ready=1.
//   - Word index = addr[ADDR_W-1:2]. Error if addr[1:0]!=0 or index>=DEPTH_WORDS:
//     no storage update, resp_rdata=0, resp_err=1. Error is a response, not a hang.
//   - Store: only bytes with be[i]=1 are written; be=0000 is a legal no-op store.
//     Store response: resp_rdata=0, resp_err=0 (unless error).
//   - Load: resp_rdata = full word at index (be ignored).
//   - Inputs are sampled only at the accept edge; changes afterwards have no effect.
//   - resp_ready while not in RESP is ignored; req_valid outside IDLE is ignored.
//   - Reset mid-operation: returns to IDLE at that edge; a store still in WAIT is
//     dropped (not written); a store already performed stays written; a pending
//     response is discarded (resp_valid=0 next cycle).
//   - Load directly after store to same word returns the updated word.
// TESTING
//   1 Reset: rst high 2 cycles -> resp_valid=0, resp_rdata=0, resp_err=0, busy=0,
//     req_ready=1 first cycle after rst low.
//   2 Store 0xDEADBEEF to 0x10 be=1111, then load 0x10 -> rdata=0xDEADBEEF,
//     err=0, resp_valid rises exactly WAIT_CYCLES+2 cycles after each accept.
//   3 Store 0x000000AA to 0x10 be=0001 then load -> rdata=0xDEADBEAA; be=0000
//     store leaves word unchanged.
//   4 Load 0x12 (misaligned) and 0x400 (DEPTH_WORDS=256) -> err=1, rdata=0;
//     subsequent load 0x10 unaffected.
//   5 Backpressure: hold resp_ready=0 5 cycles -> resp_valid/rdata stable,
//     req_ready=0, new req_valid ignored; release -> IDLE next cycle.
//   6 Assert rst during WAIT of store 0x55555555 to 0x20 (prior 0x11111111) ->
//     IDLE next cycle, later load 0x20 returns 0x11111111.

Source files
------------

// File: rtl/data_mem_if.sv
// Load/store bus between a CPU data port (master) and the data-memory responder (slave).
// Request channel and response channel each use a valid/ready handshake.
interface data_mem_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [3:0]        req_be;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory with fixed wait states. It handles one load/store at a time:
// accept, wait, access, then hold the response until it is consumed.
module data_mem_responder #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  data_mem_if.slave     bus,
  output logic          busy
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic [31:0]       mem [DEPTH_WORDS];

  logic              accept;
  logic              access;
  logic              req_err;
  logic              mem_we;
  logic [IDX_W-1:0]  idx;

  assign idx     = addr_q[IDX_W+1:2];
  // Any set bit above the index field means the word index is at or past DEPTH_WORDS.
  assign req_err = (addr_q[1:0] != 2'b00) || (|addr_q[ADDR_W-1:IDX_W+2]);
  assign accept  = (state_q == S_IDLE) && bus.req_valid;
  assign access  = (state_q == S_WAIT) && (cnt_q == 4'd0);
  assign mem_we  = access && write_q && !req_err && !rst;

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign busy           = (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_WAIT;
          cnt_d   = 4'(WAIT_CYCLES);
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else               state_d = S_RESP;
      end
      S_RESP: begin
        if (bus.resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (access) begin
        err_q   <= req_err;
        rdata_q <= (!write_q && !req_err) ? mem[idx] : 32'd0;
      end
    end
  end

  // Request fields are captured only at the accept edge and held through the access.
  always_ff @(posedge clk) begin
    if (accept) begin
      write_q <= bus.req_write;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      be_q    <= bus.req_be;
    end
  end

  // Storage has no reset; a store only lands at its access edge when rst is low.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end
endmodule
